// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: per-pin pad drive with OE turnaround, debounced input, edge irq and conflict detect
module pad_gpio_ctrl #(
    parameter int WIDTH    = 16,
    parameter int DB_LEN   = 4,
    parameter int TURN_LEN = 2
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] dout_i,
    input  logic [WIDTH-1:0] oe_req_i,
    input  logic [WIDTH-1:0] irq_en_i,
    input  logic             conflict_clr_i,
    input  logic [WIDTH-1:0] pad_in_i,
    output logic [WIDTH-1:0] pad_out_o,
    output logic [WIDTH-1:0] pad_oe_o,
    output logic [WIDTH-1:0] din_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             irq_o,
    output logic [WIDTH-1:0] conflict_o
);
    localparam logic [1:0] ST_IN   = 2'd0;
    localparam logic [1:0] ST_TURN = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;
    localparam logic [2:0] TURN_LAST = 3'(TURN_LEN - 1);
    localparam logic [3:0] DB_LAST   = 4'(DB_LEN - 1);

    logic [WIDTH-1:0] sync_1, sync;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pad_out_o <= '0;
            sync_1    <= '0;
            sync      <= '0;
        end else begin
            pad_out_o <= dout_i;
            sync_1    <= pad_in_i;
            sync      <= sync_1;
        end
    end

    assign irq_o = |((rise_o | fall_o) & irq_en_i);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] st;
        logic [2:0] tcnt;
        logic [3:0] dcnt;
        logic [1:0] stab;
        logic       oe_q, din_q, rise_q, fall_q, cfl_q;
        logic       db_take;

        // accept the new level on the DB_LEN-th consecutive differing sample
        assign db_take = (sync[i] != din_q) && (dcnt == DB_LAST);

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                st     <= ST_IN;
                tcnt   <= '0;
                dcnt   <= '0;
                stab   <= '0;
                oe_q   <= 1'b0;
                din_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                cfl_q  <= 1'b0;
            end else begin
                if (!oe_req_i[i]) begin
                    st <= ST_IN;
                end else if (st == ST_IN) begin
                    st   <= ST_TURN;
                    tcnt <= '0;
                end else if (st == ST_TURN) begin
                    if (tcnt == TURN_LAST) st <= ST_OUT;
                    else tcnt <= tcnt + 3'd1;
                end
                oe_q   <= (st == ST_OUT);
                dcnt   <= (sync[i] == din_q || db_take) ? 4'd0 : dcnt + 4'd1;
                din_q  <= db_take ? sync[i] : din_q;
                rise_q <= db_take & sync[i];
                fall_q <= db_take & ~sync[i];
                stab   <= (st == ST_OUT && dout_i[i] == pad_out_o[i]) ? ((stab == 2'd3) ? 2'd3 : stab + 2'd1) : 2'd0;
                cfl_q  <= (stab == 2'd3 && sync[i] != pad_out_o[i]) | (cfl_q & ~conflict_clr_i);
            end
        end

        assign pad_oe_o[i]   = oe_q;
        assign din_o[i]      = din_q;
        assign rise_o[i]     = rise_q;
        assign fall_o[i]     = fall_q;
        assign conflict_o[i] = cfl_q;
    end
endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// tb_pad_gpio_ctrl: directed checks of turnaround, debounce, irq, conflict and async reset
module tb_pad_gpio_ctrl;
    localparam int W = 16;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [W-1:0] dout_i = '0, oe_req_i = '0, irq_en_i = '0, pad_in_i = '0;
    logic         conflict_clr_i = 1'b0;
    logic [W-1:0] pad_out_o, pad_oe_o, din_o, rise_o, fall_o, conflict_o;
    logic         irq_o;

    int n_chk = 0;
    int n_pass = 0;

    pad_gpio_ctrl #(.WIDTH(W), .DB_LEN(4), .TURN_LEN(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .dout_i(dout_i), .oe_req_i(oe_req_i),
        .irq_en_i(irq_en_i), .conflict_clr_i(conflict_clr_i), .pad_in_i(pad_in_i),
        .pad_out_o(pad_out_o), .pad_oe_o(pad_oe_o), .din_o(din_o), .rise_o(rise_o),
        .fall_o(fall_o), .irq_o(irq_o), .conflict_o(conflict_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] all_out();
        return {16'h0, pad_out_o | pad_oe_o | din_o | rise_o | fall_o | conflict_o | {15'h0, irq_o}};
    endfunction

    initial begin
        logic [31:0] acc;
        int          nr;
        // reset held with inputs toggling
        acc = '0;
        for (int k = 0; k < 5; k++) begin
            dout_i = W'($urandom); oe_req_i = W'($urandom); pad_in_i = W'($urandom);
            irq_en_i = W'($urandom); conflict_clr_i = 1'($urandom);
            tick();
            acc |= all_out();
        end
        chk("reset_hold", acc, 0);
        dout_i = '0; oe_req_i = '0; pad_in_i = '0; irq_en_i = '0; conflict_clr_i = 1'b0;
        @(negedge HCLK) HRESETn = 1'b1;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            acc |= all_out();
        end
        chk("after_release", acc, 0);

        dout_i = 16'hA5A5;
        tick();
        chk("pad_out", pad_out_o, 32'hA5A5);
        dout_i = '0;
        tick();

        // turnaround on bit 3
        oe_req_i = 16'h0008;
        tick(); chk("turn_e0", pad_oe_o, 0);
        tick(); chk("turn_e1", pad_oe_o, 0);
        tick(); chk("turn_e2", pad_oe_o, 0);
        tick(); chk("turn_e3", pad_oe_o, 32'h0008);
        for (int k = 4; k < 10; k++) tick();
        oe_req_i = '0;
        tick(); chk("release_e10", pad_oe_o, 32'h0008);
        tick(); chk("release_e11", pad_oe_o, 0);
        oe_req_i = 16'h0008;
        tick();
        tick();
        oe_req_i = '0;
        acc = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            acc |= {16'h0, pad_oe_o};
        end
        chk("abort_turn", acc, 0);

        // debounce bit 0
        pad_in_i = 16'h0001;
        acc = '0;
        nr = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k < 5) acc |= {16'h0, din_o};
            if (k == 5) begin
                chk("db_din_e5", din_o, 32'h0001);
                chk("db_rise_e5", rise_o, 32'h0001);
            end
            nr += int'(rise_o[0]);
        end
        chk("db_din_early", acc, 0);
        chk("db_rise_count", nr, 1);
        pad_in_i = '0;
        tick(); tick(); tick();
        pad_in_i = 16'h0001;
        acc = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            acc |= {16'h0, rise_o | fall_o};
            if (din_o[0] !== 1'b1) acc[31] = 1'b1;
        end
        chk("glitch_reject", acc, 0);

        // interrupt on falling edges
        pad_in_i = 16'h0003;
        for (int k = 0; k < 8; k++) tick();
        chk("irq_setup_din", din_o, 32'h0003);
        irq_en_i = 16'h0001;
        pad_in_i = 16'h0000;
        for (int k = 0; k < 5; k++) tick();
        chk("irq_before", irq_o, 0);
        tick();
        chk("irq_fall", fall_o, 32'h0003);
        chk("irq_pulse", irq_o, 1);
        tick();
        chk("irq_after", irq_o, 0);
        chk("fall_after", fall_o, 0);
        irq_en_i = 16'h0002;
        pad_in_i = 16'h0002;
        for (int k = 0; k < 6; k++) tick();
        chk("irq_rise_b1_din", din_o, 32'h0002);
        chk("irq_rise_b1", irq_o, 1);
        pad_in_i = '0;
        irq_en_i = 16'h0001;
        for (int k = 0; k < 8; k++) tick();

        // conflict on bit 5
        dout_i = 16'h0020;
        oe_req_i = 16'h0020;
        for (int k = 0; k < 6; k++) tick();
        chk("cfl_e5", conflict_o, 0);
        tick();
        chk("cfl_e6", conflict_o, 32'h0020);
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
        chk("cfl_set_wins", conflict_o, 32'h0020);
        pad_in_i = 16'h0020;
        tick(); tick(); tick();
        conflict_clr_i = 1'b1;
        tick();
        conflict_clr_i = 1'b0;
        chk("cfl_cleared", conflict_o, 0);
        tick(); tick();
        chk("cfl_stays_clear", conflict_o, 0);
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst_din", din_o, 32'h0020);
        chk("pre_rst_oe", pad_oe_o, 32'h0020);

        // async reset mid-turn and mid-debounce
        oe_req_i = 16'h0028;
        tick(); tick();
        pad_in_i = 16'h0021;
        tick(); tick(); tick();
        #3 HRESETn = 1'b0;
        #1;
        chk("async_oe", pad_oe_o, 0);
        chk("async_din", din_o, 0);
        chk("async_all", all_out(), 0);
        @(negedge HCLK) HRESETn = 1'b1;
        tick(); chk("rst_turn_e0", pad_oe_o, 0);
        tick(); chk("rst_turn_e1", pad_oe_o, 0);
        tick(); chk("rst_turn_e2", pad_oe_o, 0);
        tick(); chk("rst_turn_e3", pad_oe_o, 32'h0028);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
